// File: rtl/debug_tx_scheduler_pkg.sv
// rtl/debug_tx_scheduler_pkg.sv - types and constants shared by the TX scheduler files
`include "debug_coprocessor.vh"

package debug_tx_scheduler_pkg;

   localparam int DATA_W    = `DEBUG_DATA_WIDTH;
   localparam int PAYLOAD_W = `DEBUG_ACK_PAYLOAD_BITS;

   // One-hot encoding built from the shared state indices.
   typedef enum logic [4:0] {
      S_IDLE         = 5'(1 << `DEBUG_S_IDLE_IDX),
      S_REPLY_START  = 5'(1 << `DEBUG_S_REPLY_START_IDX),
      S_REPLY_ACTIVE = 5'(1 << `DEBUG_S_REPLY_ACTIVE_IDX),
      S_CON_TX       = 5'(1 << `DEBUG_S_CON_TX_IDX),
      S_CON_WAIT     = 5'(1 << `DEBUG_S_CON_WAIT_IDX)
   } sched_state_t;

endpackage

// File: rtl/debug_console_fifo.sv
// rtl/debug_console_fifo.sv - synchronous console byte FIFO with count, full and empty
`include "debug_coprocessor.vh"

module debug_console_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/debug_coprocessor.vh
// rtl/debug_coprocessor.vh - shared widths and FSM state indices for the debug coprocessor
// Define DEBUG_CONSOLE_EN on the build command line to compile in the console path.
`ifndef DEBUG_COPROCESSOR_VH
`define DEBUG_COPROCESSOR_VH

`define DEBUG_DATA_WIDTH        8
`define DEBUG_ACK_PAYLOAD_BITS  32

`define DEBUG_S_IDLE_IDX          0
`define DEBUG_S_REPLY_START_IDX   1
`define DEBUG_S_REPLY_ACTIVE_IDX  2
`define DEBUG_S_CON_TX_IDX        3
`define DEBUG_S_CON_WAIT_IDX      4

`endif

// File: rtl/debug_tx_scheduler.sv
// rtl/debug_tx_scheduler.sv - shares the OCD UART TX between reply frames and console bytes (DEBUG_CONSOLE_EN adds the console path)
`include "debug_coprocessor.vh"

module debug_tx_scheduler
   import debug_tx_scheduler_pkg::*;
#(
   parameter int CONSOLE_FIFO_DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               reply_req,
   input  logic [`DEBUG_ACK_PAYLOAD_BITS-1:0] req_payload,
   output logic                               reply_enable_out,
   output logic [`DEBUG_ACK_PAYLOAD_BITS-1:0] reply_payload,
   input  logic                               reply_start_tx,
   input  logic [`DEBUG_DATA_WIDTH-1:0]       reply_data,
   output logic                               reply_tx_done,
   input  logic                               reply_done,
   input  logic                               console_valid,
   input  logic [`DEBUG_DATA_WIDTH-1:0]       console_data,
   output logic                               console_ready,
   output logic                               uart_start_tx,
   output logic [`DEBUG_DATA_WIDTH-1:0]       uart_data_out,
   input  logic                               uart_tx_done,
   output logic                               reply_overrun
);

   sched_state_t        state;
   sched_state_t        next_state;
   logic                pending;
   logic                last_was_reply;
   logic                fifo_empty;
   logic [DATA_W-1:0]   fifo_head;

`ifdef DEBUG_CONSOLE_EN
   localparam int CNT_W = $clog2(CONSOLE_FIFO_DEPTH + 1);

   logic             fifo_full;
   logic             fifo_pop;
   logic [CNT_W-1:0] unused_fifo_count;

   assign console_ready = !fifo_full;
   assign fifo_pop      = (state == S_CON_WAIT) && uart_tx_done;

   debug_console_fifo #(
      .DEPTH (CONSOLE_FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_console_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (console_valid && console_ready),
      .push_data (console_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .count     (unused_fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
`else
   logic unused_console;

   assign console_ready  = 1'b0;
   assign fifo_empty     = 1'b1;
   assign fifo_head      = '0;
   assign unused_console = ^{console_valid, console_data, CONSOLE_FIFO_DEPTH[0]};
`endif

   // A request is taken only into an empty slot; anything else is an overrun.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending        <= 1'b0;
         reply_payload  <= '0;
         reply_overrun  <= 1'b0;
         last_was_reply <= 1'b0;
      end else begin
         if (reply_req && !pending) begin
            pending       <= 1'b1;
            reply_payload <= req_payload;
         end else if (state == S_REPLY_START) begin
            pending <= 1'b0;
         end
         if (reply_req && pending) begin
            reply_overrun <= 1'b1;
         end
         if (state == S_REPLY_START) begin
            last_was_reply <= 1'b1;
         end else if ((state == S_CON_WAIT) && uart_tx_done) begin
            last_was_reply <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (pending && !fifo_empty) begin
               next_state = last_was_reply ? S_CON_TX : S_REPLY_START;
            end else if (pending) begin
               next_state = S_REPLY_START;
            end else if (!fifo_empty) begin
               next_state = S_CON_TX;
            end
         end
         S_REPLY_START:  next_state = S_REPLY_ACTIVE;
         S_REPLY_ACTIVE: if (reply_done) next_state = S_IDLE;
         S_CON_TX:       next_state = S_CON_WAIT;
         S_CON_WAIT:     if (uart_tx_done) next_state = S_IDLE;
         default:        next_state = S_IDLE;
      endcase
   end

   // UART mux: purely a function of the registered state, no added latency.
   always_comb begin
      reply_enable_out = 1'b0;
      reply_tx_done    = 1'b0;
      uart_start_tx    = 1'b0;
      uart_data_out    = '0;
      case (state)
         S_REPLY_START: begin
            reply_enable_out = 1'b1;
         end
         S_REPLY_ACTIVE: begin
            uart_start_tx = reply_start_tx;
            uart_data_out = reply_data;
            reply_tx_done = uart_tx_done;
         end
         S_CON_TX: begin
            uart_start_tx = 1'b1;
            uart_data_out = fifo_head;
         end
         S_CON_WAIT: begin
            uart_data_out = fifo_head;
         end
         default: begin
            reply_enable_out = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_debug_tx_scheduler.sv
// tb/tb_debug_tx_scheduler.sv - self-checking bench for debug_tx_scheduler against a transaction-level model
`include "debug_coprocessor.vh"

module tb_debug_tx_scheduler;

   localparam int DW = `DEBUG_DATA_WIDTH;
   localparam int PW = `DEBUG_ACK_PAYLOAD_BITS;
`ifdef DEBUG_CONSOLE_EN
   localparam bit CON_EN = 1'b1;
`else
   localparam bit CON_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          reply_req;
   logic [PW-1:0] req_payload;
   logic          reply_enable_out;
   logic [PW-1:0] reply_payload;
   logic          reply_start_tx;
   logic [DW-1:0] reply_data;
   logic          reply_tx_done;
   logic          reply_done;
   logic          console_valid;
   logic [DW-1:0] console_data;
   logic          console_ready;
   logic          uart_start_tx;
   logic [DW-1:0] uart_data_out;
   logic          uart_tx_done;
   logic          reply_overrun;

   int compared   = 0;
   int mismatched = 0;
   bit ovr_exp    = 1'b0;

   logic [DW-1:0] feed[$];
   logic [8:0]    log_q[$];
   logic [8:0]    exp_q[$];

   always #5 clk = ~clk;

   debug_tx_scheduler #(.CONSOLE_FIFO_DEPTH(16)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .reply_req        (reply_req),
      .req_payload      (req_payload),
      .reply_enable_out (reply_enable_out),
      .reply_payload    (reply_payload),
      .reply_start_tx   (reply_start_tx),
      .reply_data       (reply_data),
      .reply_tx_done    (reply_tx_done),
      .reply_done       (reply_done),
      .console_valid    (console_valid),
      .console_data     (console_data),
      .console_ready    (console_ready),
      .uart_start_tx    (uart_start_tx),
      .uart_data_out    (uart_data_out),
      .uart_tx_done     (uart_tx_done),
      .reply_overrun    (reply_overrun)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_idle(input string tag);
      check({tag, "_en"},    64'(reply_enable_out), 64'd0);
      check({tag, "_start"}, 64'(uart_start_tx),    64'd0);
      check({tag, "_data"},  64'(uart_data_out),    64'd0);
      check({tag, "_txd"},   64'(reply_tx_done),    64'd0);
   endtask

   // One reply frame issued while idle, with k extra requests during the frame.
   task automatic reply_frame_test(input logic [PW-1:0] p, input int k);
      logic [PW-1:0] q;
      logic [DW-1:0] b;
      q = p;
      reply_req = 1'b1; req_payload = p; #1;
      check("en_t0", 64'(reply_enable_out), 64'd0);
      step(); reply_req = 1'b0; req_payload = $urandom; #1;
      check("en_t1", 64'(reply_enable_out), 64'd0);
      check("pay_t1", 64'(reply_payload), 64'(p));
      step();
      check("en_t2", 64'(reply_enable_out), 64'd1);
      step();
      check("en_t3", 64'(reply_enable_out), 64'd0);
      b = DW'($urandom);
      reply_start_tx = 1'b1; reply_data = b; #1;
      check("pass_start", 64'(uart_start_tx), 64'd1);
      check("pass_data", 64'(uart_data_out), 64'(b));
      step(); reply_start_tx = 1'b0; uart_tx_done = 1'b1; #1;
      check("pass_nostart", 64'(uart_start_tx), 64'd0);
      check("pass_txdone", 64'(reply_tx_done), 64'd1);
      step(); uart_tx_done = 1'b0;
      for (int i = 0; i < k; i++) begin
         reply_req = 1'b1; req_payload = $urandom;
         if (i == 0) q = req_payload;
         step(); reply_req = 1'b0; #1;
         check("pay_queued", 64'(reply_payload), 64'(q));
      end
      if (k >= 2) ovr_exp = 1'b1;
      check("overrun", 64'(reply_overrun), 64'(ovr_exp));
      check("frame_en", 64'(reply_enable_out), 64'd0);
      reply_done = 1'b1;
      step(); reply_done = 1'b0; #1;
      check("en_d1", 64'(reply_enable_out), 64'd0);
      step();
      check("en_d2", 64'(reply_enable_out), 64'(k > 0));
      if (k > 0) begin
         check("pay_second", 64'(reply_payload), 64'(q));
         step(); reply_done = 1'b1;
         step(); reply_done = 1'b0;
         step();
         check("en_no_third_a", 64'(reply_enable_out), 64'd0);
         step();
         check("en_no_third_b", 64'(reply_enable_out), 64'd0);
      end
   endtask

   // Bench-side reply engine (one byte per frame) and UART (done 2 cycles after start).
   task automatic service(input int ncyc, input bit kick);
      int rstate;
      int ucnt;
      rstate = 0;
      ucnt = kick ? 0 : -1;
      for (int c = 0; c < ncyc; c++) begin
         reply_start_tx = 1'b0; reply_done = 1'b0; uart_tx_done = 1'b0; console_valid = 1'b0;
         if (ucnt == 0) begin uart_tx_done = 1'b1; ucnt = -1; end
         if (rstate == 1) begin reply_start_tx = 1'b1; reply_data = 8'hA5; rstate = 2; end
         else if (rstate == 3) begin reply_done = 1'b1; rstate = 0; end
         if (feed.size() > 0 && $urandom_range(0, 3) != 0) begin
            console_valid = 1'b1; console_data = feed[0];
         end
         #1;
         if (reply_enable_out) begin log_q.push_back(9'h100); rstate = 1; end
         if (uart_start_tx && !reply_start_tx) log_q.push_back({1'b0, uart_data_out});
         if (uart_start_tx) ucnt = 2;
         if (rstate == 2 && reply_tx_done) rstate = 3;
         if (console_valid && console_ready) void'(feed.pop_front());
         @(posedge clk); #1;
         if (ucnt > 0) ucnt--;
      end
      reply_start_tx = 1'b0; reply_done = 1'b0; uart_tx_done = 1'b0; console_valid = 1'b0;
   endtask

   task automatic check_log(input string tag);
      check({tag, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         check({tag, "_item"}, 64'(log_q[i]), 64'(exp_q[i]));
      end
      log_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset_n = 1'b0; reply_req = 1'b0; req_payload = '0; reply_start_tx = 1'b0;
      reply_data = '0; reply_done = 1'b0; console_valid = 1'b0; console_data = '0;
      uart_tx_done = 1'b0;
      step(); step();
      check_outputs_idle("rst");
      check("rst_pay", 64'(reply_payload), 64'd0);
      check("rst_ovr", 64'(reply_overrun), 64'd0);
      check("rst_ready", 64'(console_ready), 64'(CON_EN));
      reset_n = 1'b1;
      step();

      // Ungranted inputs must not reach the UART or the reply engine.
      uart_tx_done = 1'b1; reply_start_tx = 1'b1; reply_data = 8'h5A; #1;
      check_outputs_idle("gate_idle");
      step(); uart_tx_done = 1'b0; reply_start_tx = 1'b0;

      reply_frame_test(32'h1234_5678, 0);
      reply_frame_test($urandom, 3);
      for (int n = 0; n < 8; n++) begin
         repeat ($urandom_range(0, 3)) step();
         reply_frame_test($urandom, $urandom_range(0, 3));
      end

      // Reset in the middle of a granted frame.
      reply_req = 1'b1; req_payload = $urandom;
      step(); reply_req = 1'b0;
      step(); step();
      reply_start_tx = 1'b1; reply_data = 8'hC3; #1;
      check("mid_start", 64'(uart_start_tx), 64'd1);
      reset_n = 1'b0; #1;
      check_outputs_idle("mid_rst");
      check("mid_rst_pay", 64'(reply_payload), 64'd0);
      check("mid_rst_ovr", 64'(reply_overrun), 64'd0);
      ovr_exp = 1'b0;
      step(); reply_start_tx = 1'b0;
      reset_n = 1'b1;
      step();
      reply_frame_test(32'h1234_5678, 0);

`ifdef DEBUG_CONSOLE_EN
      // Three console bytes in order.
      feed = '{8'h41, 8'h42, 8'h43};
      exp_q = '{9'h041, 9'h042, 9'h043};
      service(60, 1'b0);
      check_log("con3");
      check("con3_ready", 64'(console_ready), 64'd1);

      // Fairness with last_was_reply set: console, reply, console.
      reply_frame_test($urandom, 0);
      reply_req = 1'b1; req_payload = $urandom; console_valid = 1'b1; console_data = 8'h41;
      step(); reply_req = 1'b0; console_data = 8'h42;
      step(); console_valid = 1'b0;
      exp_q = '{9'h041, 9'h100, 9'h042};
      service(60, 1'b0);
      check_log("fair");

      // Fill to 16 with the UART stalled; byte 0 starts while filling.
      begin
         int starts;
         logic [DW-1:0] first;
         starts = 0; first = '0;
         for (int i = 0; i < 16; i++) begin
            console_valid = 1'b1; console_data = DW'(8'h60 + i); #1;
            check("fill_ready", 64'(console_ready), 64'd1);
            if (uart_start_tx) begin starts++; first = uart_data_out; end
            step();
         end
         console_data = 8'hEE; #1;
         check("full_ready", 64'(console_ready), 64'd0);
         step(); #1;
         check("full_ready2", 64'(console_ready), 64'd0);
         console_valid = 1'b0;
         check("fill_starts", 64'(starts), 64'd1);
         check("fill_first", 64'(first), 64'h60);
      end
      for (int i = 1; i < 16; i++) exp_q.push_back(9'(8'h60 + i));
      service(300, 1'b1);
      check_log("full");
      check("full_drained_ready", 64'(console_ready), 64'd1);

      // 40 random bytes streamed through the FIFO, exercising pointer wrap.
      for (int i = 0; i < 40; i++) begin
         feed.push_back(DW'($urandom));
         exp_q.push_back({1'b0, feed[i]});
      end
      service(1500, 1'b0);
      check_log("wrap");
      check("wrap_fed", 64'(feed.size()), 64'd0);
`else
      // Console path compiled out: bytes are never accepted or sent.
      for (int i = 0; i < 10; i++) begin
         console_valid = 1'b1; console_data = DW'($urandom); #1;
         check("nocon_ready", 64'(console_ready), 64'd0);
         check("nocon_start", 64'(uart_start_tx), 64'd0);
         step();
      end
      console_valid = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
